// File: rtl/mdu_seq_if.sv
// Operand, control and result bundle between the main control FSM and the
// multiply/divide sequencer.
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative mult/multu/div/divu sequencer, one bit per cycle, owning HI/LO.
// state  | meaning
// IDLE   | waiting for start; mthi/mtlo writes accepted
// PREP   | magnitudes and sign flags, counter load
// RUN    | WIDTH shift-add / restoring-divide steps
// FIX    | sign fix-up, divide-by-zero override, HI/LO write
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_top;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // op[0]=0 selects the signed variants
  assign sign_a     = a_q[WIDTH-1] & ~op_q[0];
  assign sign_b     = opnd_q[WIDTH-1] & ~op_q[0];
  assign mag_a      = sign_a ? -a_q : a_q;
  assign mag_b      = sign_b ? -opnd_q : opnd_q;

  assign mul_addend = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

  // Shifted partial remainder keeps its carry-out bit so divisors above
  // 2^(WIDTH-1) compare correctly.
  assign div_top    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff   = {1'b0, div_top} - {2'b00, opnd_q};

  assign prod_fix   = neg_res_q ? -acc_q : acc_q;
  assign quo_fix    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          opnd_d  = bus.b;
          dz_d    = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_res_d = sign_a ^ sign_b;
        neg_rem_d = sign_a;
        cnt_d     = CW'(WIDTH - 1);
        if (op_q[1]) begin
          acc_d  = {{WIDTH{1'b0}}, mag_a};
          opnd_d = mag_b;
        end else begin
          acc_d  = {{WIDTH{1'b0}}, mag_b};
          opnd_d = mag_a;
        end
        state_d = S_RUN;
      end
      S_RUN: begin
        if (op_q[1]) begin
          if (!div_diff[WIDTH+1])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          if (opnd_q == '0) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = a_q;
            dz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: reference results queued at start, compared on done.
module tb_mdu_seq;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(W)) bus ();
  mdu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           n_chk  = 0;
  int           n_fail = 0;
  int           n_done = 0;
  logic [W-1:0] last_hi = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sa, sb;
    sa   = a;
    sb   = b;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      2'd0: begin
        p    = longint'(sa) * longint'(sb);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'd1: begin
        p    = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
          e.dz = 1'b1;
        end else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'h0;
        end else if (op == 2'd2) begin
          e.lo = sa / sb;
          e.hi = sa % sb;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e   = sb_q.pop_front();
        last_hi = mon_e.hi;
        check("hi", bus.hi, mon_e.hi);
        check("lo", bus.lo, mon_e.lo);
        check("dz", bus.dz, mon_e.dz);
      end
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bc;
    start_op(op, a, b);
    wait_done(lat, bc);
    check("latency", lat, 35);
    check("busy_cycles", bc, 34);
    check("busy_at_done", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, d0;
    logic [W-1:0] rb;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz",   bus.dz,   0);
    check("rst_hi",   bus.hi,   0);
    check("rst_lo",   bus.lo,   0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd3, 32'd7, 32'd2);
    run_op(2'd3, 32'd7, 32'd0);
    @(negedge clk);
    check("dz_sticky", bus.dz, 1);
    run_op(2'd1, 32'd2, 32'd3);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd9, 32'd0);
    run_op(2'd0, 32'd4, 32'd4);
    check("dz_mult_cleared", bus.dz, 0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001);

    for (int i = 0; i < 8; i++) begin
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 4) == 0) rb = '0;
      run_op(2'($urandom_range(0, 3)), $urandom, rb);
    end

    // second start and mthi while busy must both be dropped
    start_op(2'd1, 32'h1234_5678, 32'h100);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      lat = i;
      if (bus.done) break;
      if (i == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'd99;
        bus.b     = 32'd3;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234;
      end else begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
      if (i == 6) check("hi_we_ignored", bus.hi, last_hi);
    end
    check("ignore_latency", lat, 35);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hABCD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo_lo", bus.lo, 32'hABCD);
    check("mtlo_hi", bus.hi, 32'h12);
    d0 = n_done;
    repeat (40) @(negedge clk);
    check("no_extra_done", n_done, d0);

    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h55AA;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthi_both", bus.hi, 32'h55AA);
    check("mtlo_both", bus.lo, 32'h55AA);

    // reset during RUN step 10 must abort with no result
    run_op(2'd3, 32'd100, 32'd0);
    start_op(2'd2, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hi",   bus.hi,   0);
    check("abort_lo",   bus.lo,   0);
    check("abort_dz",   bus.dz,   0);
    d0 = n_done;
    repeat (40) @(negedge clk);
    check("abort_no_done", n_done, d0);
    run_op(2'd3, 32'd100, 32'd7);

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
